// File: rtl/tank_ai_keygen.sv
// ----------------------------------------------------------------------------
// tank_ai_keygen
//
// Autonomous keycode source for a CPU-controlled tank. It emits the same 8-bit
// keycode stream a keyboard would (W/A/S/D move, Space fire, 0x00 idle). That
// stream feeds a tank movement/bullet controller, and the controller's
// position, facing, bullet and blocked status feed back into this block. The
// behaviour is: chase the player, line up on an axis, turn to face, fire,
// then cool down. When the tank is blocked it briefly escapes sideways.
//
// Ports
//   Clk           in   1   system clock
//   Reset         in   1   synchronous, active-high
//   frame_clk     in   1   ~60 Hz frame clock, asynchronous level
//   enable        in   1   1 = AI active, 0 = force IDLE
//   own_X, own_Y  in  10   AI tank top-left pixel
//   own_dir       in   3   AI tank facing: 1 up, 2 right, 3 left, 4 down
//   target_X/Y    in  10   player tank top-left pixel
//   bullet_state  in   2   AI tank bullet status, 00 = no bullet in flight
//   can_move      in   1   0 = AI tank blocked this frame
//   keycode       out  8   key presented to the AI tank controller
//   ai_state      out  3   current FSM state (debug / LEDs)
//
// All state, counter and keycode updates happen only on the one-cycle frame
// tick. The keycode is a register and stays stable for a whole frame.
// ----------------------------------------------------------------------------
module tank_ai_keygen #(
    parameter logic [9:0] ALIGN_TOL       = 10'd8,
    parameter logic [7:0] HOLD_FRAMES     = 8'd16,
    parameter logic [7:0] FIRE_FRAMES     = 8'd1,
    parameter logic [7:0] COOLDOWN_FRAMES = 8'd60,
    parameter logic [7:0] UNSTICK_FRAMES  = 8'd24,
    parameter logic [7:0] LFSR_SEED       = 8'hA5
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       enable,
    input  logic [9:0] own_X,
    input  logic [9:0] own_Y,
    input  logic [2:0] own_dir,
    input  logic [9:0] target_X,
    input  logic [9:0] target_Y,
    input  logic [1:0] bullet_state,
    input  logic       can_move,
    output logic [7:0] keycode,
    output logic [2:0] ai_state
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CHASE   = 3'd1,
        ST_AIM     = 3'd2,
        ST_FIRE    = 3'd3,
        ST_COOL    = 3'd4,
        ST_UNSTICK = 3'd5
    } state_e;

    localparam logic [2:0] DIR_NONE  = 3'd0;
    localparam logic [2:0] DIR_UP    = 3'd1;
    localparam logic [2:0] DIR_RIGHT = 3'd2;
    localparam logic [2:0] DIR_LEFT  = 3'd3;
    localparam logic [2:0] DIR_DOWN  = 3'd4;

    localparam logic [7:0] KEY_W    = 8'h1A;
    localparam logic [7:0] KEY_D    = 8'h07;
    localparam logic [7:0] KEY_A    = 8'h04;
    localparam logic [7:0] KEY_S    = 8'h16;
    localparam logic [7:0] KEY_FIRE = 8'h2C;
    localparam logic [7:0] KEY_IDLE = 8'h00;

    // A frame count of 0 is treated as 1, so the state still lasts one frame.
    localparam logic [7:0] HOLD_LOAD    = (HOLD_FRAMES     == 8'd0) ? 8'd0 : HOLD_FRAMES     - 8'd1;
    localparam logic [7:0] FIRE_LOAD    = (FIRE_FRAMES     == 8'd0) ? 8'd0 : FIRE_FRAMES     - 8'd1;
    localparam logic [7:0] COOL_LOAD    = (COOLDOWN_FRAMES == 8'd0) ? 8'd0 : COOLDOWN_FRAMES - 8'd1;
    localparam logic [7:0] UNSTICK_LOAD = (UNSTICK_FRAMES  == 8'd0) ? 8'd0 : UNSTICK_FRAMES  - 8'd1;

    function automatic logic [7:0] key_of_dir(input logic [2:0] dir);
        case (dir)
            DIR_UP:    key_of_dir = KEY_W;
            DIR_RIGHT: key_of_dir = KEY_D;
            DIR_LEFT:  key_of_dir = KEY_A;
            DIR_DOWN:  key_of_dir = KEY_S;
            default:   key_of_dir = KEY_IDLE;
        endcase
    endfunction

    state_e     state_q, state_d;
    logic [7:0] key_q, key_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] lfsr_q, lfsr_d;
    logic       fclk_q, fclk_dly_q, tick_q;

    // ------------------------------------------------------------------------
    // Frame tick. frame_clk is sampled once, delayed once more, and the rising
    // edge between the two is registered into a single-cycle pulse.
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge Clk) begin
        // NOTE: the reset is synchronous; it is only evaluated on a Clk edge.
        if (Reset) begin
            fclk_q     <= 1'b0;
            fclk_dly_q <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            fclk_q     <= frame_clk;
            fclk_dly_q <= fclk_q;
            tick_q     <= fclk_q & ~fclk_dly_q;
        end
    end

    // ------------------------------------------------------------------------
    // Geometry. Differences are 11-bit two's complement, so the full +/-1023
    // range of screen coordinates is representable.
    // ------------------------------------------------------------------------
    logic [10:0] dx, dy, abs_dx, abs_dy;
    logic        dx_neg, dy_neg, align_x, align_y, aligned;
    logic [2:0]  desired_dir;
    logic [7:0]  chase_key, escape_key;
    logic        facing_vertical;

    assign dx     = {1'b0, target_X} - {1'b0, own_X};
    assign dy     = {1'b0, target_Y} - {1'b0, own_Y};
    assign dx_neg = dx[10];
    assign dy_neg = dy[10];
    assign abs_dx = dx_neg ? (~dx + 11'd1) : dx;
    assign abs_dy = dy_neg ? (~dy + 11'd1) : dy;

    // Small |dx| puts the target in the same column, so the shot goes up/down.
    assign align_x = (abs_dx <= {1'b0, ALIGN_TOL});
    assign align_y = (abs_dy <= {1'b0, ALIGN_TOL});
    assign aligned = align_x | align_y;

    assign desired_dir = align_x ? (dy_neg ? DIR_UP   : DIR_DOWN)  :
                         align_y ? (dx_neg ? DIR_LEFT : DIR_RIGHT) : DIR_NONE;

    // Close the larger gap first. On a tie the X axis wins.
    assign chase_key = (abs_dx >= abs_dy) ? (dx_neg ? KEY_A : KEY_D)
                                          : (dy_neg ? KEY_W : KEY_S);

    // Escape perpendicular to the current facing. The LFSR picks the side so
    // the tank does not keep ramming the same corner.
    assign facing_vertical = (own_dir == DIR_UP) || (own_dir == DIR_DOWN);
    assign escape_key = facing_vertical ? (lfsr_q[0] ? KEY_D : KEY_A)
                                        : (lfsr_q[0] ? KEY_S : KEY_W);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_d    = state_q;
        key_d      = key_q;
        hold_cnt_d = hold_cnt_q;
        cnt_d      = cnt_q;
        lfsr_d     = lfsr_q;

        if (tick_q) begin
            // Taps 8,6,5,4 (bits 7,5,4,3); advances every frame in any state.
            lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

            if (!enable) begin
                state_d = ST_IDLE;
                key_d   = KEY_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_d    = ST_CHASE;
                        key_d      = KEY_IDLE;
                        hold_cnt_d = 8'd0;
                    end

                    ST_CHASE: begin
                        if (!can_move) begin
                            state_d = ST_UNSTICK;
                            key_d   = escape_key;
                            cnt_d   = UNSTICK_LOAD;
                        end else if (hold_cnt_q == 8'd0) begin
                            if (aligned) begin
                                state_d = ST_AIM;
                                key_d   = key_of_dir(desired_dir);
                            end else begin
                                key_d      = chase_key;
                                hold_cnt_d = HOLD_LOAD;
                            end
                        end else begin
                            hold_cnt_d = hold_cnt_q - 8'd1;
                        end
                    end

                    ST_AIM: begin
                        key_d = key_of_dir(desired_dir);
                        if (!aligned) begin
                            state_d    = ST_CHASE;
                            hold_cnt_d = 8'd0;
                        end else if ((own_dir == desired_dir) && (bullet_state == 2'b00)) begin
                            // The shot key goes out on the same frame FIRE is entered.
                            state_d = ST_FIRE;
                            key_d   = KEY_FIRE;
                            cnt_d   = FIRE_LOAD;
                        end
                    end

                    ST_FIRE: begin
                        if (cnt_q == 8'd0) begin
                            state_d = ST_COOL;
                            key_d   = KEY_IDLE;
                            cnt_d   = COOL_LOAD;
                        end else begin
                            key_d = KEY_FIRE;
                            cnt_d = cnt_q - 8'd1;
                        end
                    end

                    ST_COOL: begin
                        key_d = KEY_IDLE;
                        if (cnt_q == 8'd0) begin
                            state_d    = ST_CHASE;
                            hold_cnt_d = 8'd0;
                        end else begin
                            cnt_d = cnt_q - 8'd1;
                        end
                    end

                    ST_UNSTICK: begin
                        // can_move is deliberately ignored until the escape completes.
                        if (cnt_q == 8'd0) begin
                            state_d    = ST_CHASE;
                            key_d      = KEY_IDLE;
                            hold_cnt_d = 8'd0;
                        end else begin
                            cnt_d = cnt_q - 8'd1;
                        end
                    end

                    default: begin
                        state_d = ST_IDLE;
                        key_d   = KEY_IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            key_q      <= KEY_IDLE;
            hold_cnt_q <= 8'd0;
            cnt_q      <= 8'd0;
            lfsr_q     <= LFSR_SEED;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            hold_cnt_q <= hold_cnt_d;
            cnt_q      <= cnt_d;
            lfsr_q     <= lfsr_d;
        end
    end

    assign keycode  = key_q;
    assign ai_state = state_q;

endmodule

// File: tb/tb_tank_ai_keygen.sv
// ----------------------------------------------------------------------------
// tb_tank_ai_keygen
//
// Directed bench for tank_ai_keygen. Each frame step pushes the expected
// keycode/state pair into a scoreboard queue and then pulses frame_clk. Once
// the DUT has had time to take the tick, the entry is popped and compared.
// ----------------------------------------------------------------------------
module tb_tank_ai_keygen;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_clk;
    logic       enable;
    logic [9:0] own_X, own_Y, target_X, target_Y;
    logic [2:0] own_dir;
    logic [1:0] bullet_state;
    logic       can_move;
    logic [7:0] keycode;
    logic [2:0] ai_state;

    tank_ai_keygen dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_clk    (frame_clk),
        .enable       (enable),
        .own_X        (own_X),
        .own_Y        (own_Y),
        .own_dir      (own_dir),
        .target_X     (target_X),
        .target_Y     (target_Y),
        .bullet_state (bullet_state),
        .can_move     (can_move),
        .keycode      (keycode),
        .ai_state     (ai_state)
    );

    always #10 Clk = ~Clk;

    typedef struct {
        logic [7:0] key;
        logic [2:0] state;
        string      tag;
    } exp_t;

    exp_t sb_q[$];
    int   checks     = 0;
    int   failures   = 0;
    int   tick_count = 0;   // frame ticks since the last reset

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One frame: raise frame_clk for hi_cycles Clk cycles, then compare the
    // oldest scoreboard entry while frame_clk is still high.
    task automatic frame(input int hi_cycles);
        exp_t e;
        @(negedge Clk);
        frame_clk = 1'b1;
        repeat (hi_cycles) @(negedge Clk);
        if (sb_q.size() == 0) begin
            $display("FAIL scoreboard_empty at tick %0d", tick_count);
            $fatal(1, "scoreboard underflow");
        end
        e = sb_q.pop_front();
        check({e.tag, "_key"}, keycode, e.key);
        check({e.tag, "_state"}, {5'd0, ai_state}, {5'd0, e.state});
        frame_clk = 1'b0;
        repeat (6) @(negedge Clk);
        tick_count++;
    endtask

    task automatic step(input logic [7:0] key, input logic [2:0] state, input string tag);
        exp_t e;
        e.key   = key;
        e.state = state;
        e.tag   = tag;
        sb_q.push_back(e);
        frame(6);
    endtask

    task automatic step_long(input logic [7:0] key, input logic [2:0] state, input string tag);
        exp_t e;
        e.key   = key;
        e.state = state;
        e.tag   = tag;
        sb_q.push_back(e);
        frame(400);
    endtask

    // Fibonacci LFSR x^8+x^6+x^5+x^4+1, seed A5, advanced n times.
    function automatic logic [7:0] lfsr_after(input int n);
        logic [7:0] v;
        v = 8'hA5;
        for (int i = 0; i < n; i++) v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
        return v;
    endfunction

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        check("reset_key", keycode, 8'h00);
        check("reset_state", {5'd0, ai_state}, 8'd0);
        @(negedge Clk);
        Reset = 1'b0;
        tick_count = 0;
    endtask

    initial begin
        logic [7:0] lv;
        logic [7:0] esc;

        Reset        = 1'b1;
        frame_clk    = 1'b0;
        enable       = 1'b0;
        own_X        = 10'd100;
        own_Y        = 10'd100;
        own_dir      = 3'd2;
        target_X     = 10'd300;
        target_Y     = 10'd110;
        bullet_state = 2'b00;
        can_move     = 1'b1;
        repeat (3) @(negedge Clk);
        do_reset();

        // Disabled: frames keep it in IDLE.
        step(8'h00, 3'd0, "idle_disabled");

        // --- Chase, align, aim, fire, cool down -----------------------------
        enable = 1'b1;
        step(8'h00, 3'd1, "t1_enter_chase");
        step(8'h07, 3'd1, "t1_chase_right");   // dy=10 is just outside tolerance
        own_Y = 10'd105;                       // tank drifts into row alignment
        for (int i = 0; i < 15; i++) step(8'h07, 3'd1, "t1_hold");
        step(8'h07, 3'd2, "t1_aim");
        step(8'h2C, 3'd3, "t1_fire");
        step(8'h00, 3'd4, "t1_cool_first");
        // One long-held frame_clk mid-cooldown must count as a single frame.
        for (int i = 0; i < 59; i++) begin
            if (i == 20) step_long(8'h00, 3'd4, "t6_cool_long_frame");
            else         step(8'h00, 3'd4, "t1_cool");
        end
        step(8'h00, 3'd1, "t1_back_to_chase");

        // --- Bullet in flight blocks the shot -------------------------------
        bullet_state = 2'b01;
        step(8'h07, 3'd2, "t4_aim");
        for (int i = 0; i < 3; i++) step(8'h07, 3'd2, "t4_aim_wait_bullet");
        bullet_state = 2'b00;
        step(8'h2C, 3'd3, "t4_fire_after_bullet");

        // --- enable drop during FIRE, Reset during COOL ---------------------
        enable = 1'b0;
        step(8'h00, 3'd0, "t5_disable_in_fire");
        enable = 1'b1;
        step(8'h00, 3'd1, "t5_reenable_chase");
        step(8'h07, 3'd2, "t5_aim");
        step(8'h2C, 3'd3, "t5_fire");
        step(8'h00, 3'd4, "t5_cool");
        step(8'h00, 3'd4, "t5_cool2");
        do_reset();

        // --- Tie goes to X, held exactly 16 frames --------------------------
        own_X = 10'd100; own_Y = 10'd100;
        target_X = 10'd300; target_Y = 10'd300;
        step(8'h00, 3'd1, "t2_enter_chase");
        step(8'h07, 3'd1, "t2_tie_x");
        target_Y = 10'd400;                    // Y now dominates, but the key is held
        for (int i = 0; i < 15; i++) step(8'h07, 3'd1, "t2_hold");
        step(8'h16, 3'd1, "t2_reeval_down");

        // --- Blocked while moving up -> perpendicular escape ----------------
        own_X = 10'd100; own_Y = 10'd300;
        target_X = 10'd120; target_Y = 10'd50;
        own_dir = 3'd1;
        for (int i = 0; i < 15; i++) step(8'h16, 3'd1, "t3_hold_down");
        step(8'h1A, 3'd1, "t3_chase_up");
        can_move = 1'b0;
        lv  = lfsr_after(tick_count);
        esc = lv[0] ? 8'h07 : 8'h04;
        step(esc, 3'd5, "t3_unstick");
        for (int i = 0; i < 23; i++) begin
            can_move = (i < 3) ? 1'b0 : 1'b1;  // still blocked early on: ignored
            step(esc, 3'd5, "t3_unstick_hold");
        end
        step(8'h00, 3'd1, "t3_back_to_chase");
        step(8'h1A, 3'd1, "t3_rechase_up");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
